// File: rtl/mem_stage.sv
// mem_stage: MEM pipeline stage. Consumes the EX->MEM register, runs loads and
// stores on a req/gnt/rvalid data-memory port (byte lanes, load align/extend),
// exposes forwarding/hazard taps to EX and registers results into MEM->WB.
// A per-access cycle counter aborts accesses that never complete.
module mem_stage #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu,
    input  logic [31:0] ex_rd2,
    input  logic [31:0] ex_inst,
    output logic [31:0] mem_alu,
    output logic [31:0] mem_inst,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_we,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_alu,
    output logic [31:0] wb_rdata,
    output logic [31:0] wb_inst,
    output logic        mem_misalign,
    output logic        mem_fault
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_RESP   = 1'b1;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    logic [0:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [31:0] wb_alu_q, wb_alu_d;
    logic [31:0] wb_rdata_q, wb_rdata_d;
    logic [31:0] wb_inst_q, wb_inst_d;
    logic        misalign_q, misalign_d;
    logic        fault_q, fault_d;

    logic [2:0]  funct3;
    logic        is_load, is_store, mem_op;
    logic        size_b, size_h, size_w;
    logic        misaligned, mem_go, timeout_hit;
    logic        req_int, accept, store_done, load_done, done;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] load_val;

    // Decode: funct3[1:0] selects access width, funct3[2] selects zero-extension.
    assign funct3   = ex_inst[14:12];
    assign is_load  = (ex_inst[6:0] == OPC_LOAD);
    assign is_store = (ex_inst[6:0] == OPC_STORE);
    assign mem_op   = is_load || is_store;
    assign size_b   = (funct3[1:0] == 2'b00);
    assign size_h   = (funct3[1:0] == 2'b01);
    assign size_w   = !size_b && !size_h;

    // Misaligned accesses never reach the memory port; they are dropped as a bubble.
    assign misaligned  = mem_op && ((size_h && ex_alu[0]) || (size_w && (ex_alu[1:0] != 2'b00)));
    assign mem_go      = mem_op && !misaligned;
    assign timeout_hit = mem_go && (TIMEOUT != 8'd0) && (cnt_q == TIMEOUT);

    // The request is gated by rst_n so it drops immediately when reset asserts.
    assign req_int    = (state_q == ST_IDLE) && mem_go && !timeout_hit;
    assign dmem_req   = rst_n && req_int;
    assign accept     = dmem_req && dmem_gnt;
    assign store_done = accept && is_store;
    assign load_done  = (state_q == ST_RESP) && mem_go && dmem_rvalid && !timeout_hit;
    assign done       = store_done || load_done || timeout_hit;
    assign mem_stall  = rst_n && mem_go && !done;

    assign mem_alu   = ex_alu;
    assign mem_inst  = ex_inst;
    assign dmem_addr = {ex_alu[31:2], 2'b00};

    // Per-lane write enable and lane-replicated store data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign dmem_we[gi] = is_store && (size_w
                                       || (size_h && (ex_alu[1] == LANE[1]))
                                       || (size_b && (ex_alu[1:0] == LANE)));
        assign dmem_wdata[8*gi +: 8] = size_w ? ex_rd2[8*gi +: 8]
                                     : size_h ? ex_rd2[8*(gi%2) +: 8]
                                     : ex_rd2[7:0];
    end

    // Pick the addressed byte and half-word out of the returned word.
    always_comb begin
        ld_byte = dmem_rdata[7:0];
        case (ex_alu[1:0])
            2'd0:    ld_byte = dmem_rdata[7:0];
            2'd1:    ld_byte = dmem_rdata[15:8];
            2'd2:    ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = ex_alu[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    end

    // Sign- or zero-extend the extracted load value.
    always_comb begin
        load_val = dmem_rdata;
        case (funct3)
            3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
            3'b100:  load_val = {24'd0, ld_byte};
            3'b101:  load_val = {16'd0, ld_half};
            default: load_val = dmem_rdata;
        endcase
    end

    // Access FSM and per-access cycle counter; RESP falls back to IDLE if the op vanishes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_load) state_d = ST_RESP;
            default: if (!mem_go || load_done || timeout_hit) state_d = ST_IDLE;
        endcase
        cnt_d = (done || !mem_go) ? 8'd0 : cnt_q + 8'd1;
    end

    // Next values for MEM->WB; stalled, dropped and aborted ops become bubbles.
    always_comb begin
        wb_pc_d    = ex_pc;
        wb_alu_d   = ex_alu;
        wb_rdata_d = load_done ? load_val : 32'd0;
        wb_inst_d  = (mem_stall || misaligned || timeout_hit) ? NOP_INST : ex_inst;
        misalign_d = misaligned;
        fault_d    = timeout_hit;
    end

    // State, counter and MEM->WB registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            wb_pc_q    <= 32'd0;
            wb_alu_q   <= 32'd0;
            wb_rdata_q <= 32'd0;
            wb_inst_q  <= NOP_INST;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_pc_q    <= wb_pc_d;
            wb_alu_q   <= wb_alu_d;
            wb_rdata_q <= wb_rdata_d;
            wb_inst_q  <= wb_inst_d;
            misalign_q <= misalign_d;
            fault_q    <= fault_d;
        end
    end

    assign wb_pc        = wb_pc_q;
    assign wb_alu       = wb_alu_q;
    assign wb_rdata     = wb_rdata_q;
    assign wb_inst      = wb_inst_q;
    assign mem_misalign = misalign_q;
    assign mem_fault    = fault_q;

endmodule
